// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine change path.
//   - coin codes as driven on eject_coin / refill_coin
//   - coin face values in cents
//   - state encoding for the change sequencer FSM
//   - coin_value(): maps a coin code to its value in cents
package vend_pkg;

    typedef logic [1:0] coin_t;
    typedef logic [1:0] state_t;

    localparam coin_t NICKEL  = 2'd0;
    localparam coin_t DIME    = 2'd1;
    localparam coin_t QUARTER = 2'd2;
    localparam coin_t DOLLAR  = 2'd3;

    localparam logic [7:0] NICKEL_CENTS  = 8'd5;
    localparam logic [7:0] DIME_CENTS    = 8'd10;
    localparam logic [7:0] QUARTER_CENTS = 8'd25;
    localparam logic [7:0] DOLLAR_CENTS  = 8'd100;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SELECT = 2'd1;
    localparam state_t EJECT  = 2'd2;
    localparam state_t DONE   = 2'd3;

    function automatic logic [7:0] coin_value(input coin_t coin);
        logic [7:0] value;
        case (coin)
            NICKEL:  value = NICKEL_CENTS;
            DIME:    value = DIME_CENTS;
            QUARTER: value = QUARTER_CENTS;
            default: value = DOLLAR_CENTS;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/coin_change_sequencer_if.sv
// Request and coin-ejection handshakes of the change sequencer.
//   req_valid / req_ready / req_cents : change request from the vending logic
//   eject_valid / eject_coin / eject_ack : one-coin-at-a-time hopper handshake
// master: vending logic + hoppers.  slave: the sequencer.
interface coin_change_sequencer_if;
    import vend_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_cents;
    logic       eject_valid;
    coin_t      eject_coin;
    logic       eject_ack;

    modport master (
        output req_valid,
        output req_cents,
        output eject_ack,
        input  req_ready,
        input  eject_valid,
        input  eject_coin
    );

    modport slave (
        input  req_valid,
        input  req_cents,
        input  eject_ack,
        output req_ready,
        output eject_valid,
        output eject_coin
    );

endinterface

// File: rtl/coin_select.sv
// Combinational greedy coin picker.
//   remain_cents : amount still owed
//   inv_nz       : per-coin "inventory not empty" flags, indexed by coin code
//   found        : some coin is both affordable and in stock
//   coin         : largest such coin (dollar, quarter, dime, nickel order)
module coin_select
    import vend_pkg::*;
(
    input  logic [7:0] remain_cents,
    input  logic [3:0] inv_nz,
    output logic       found,
    output coin_t      coin
);

    always_comb begin
        found = 1'b0;
        coin  = NICKEL;
        if (inv_nz[DOLLAR] && remain_cents >= DOLLAR_CENTS) begin
            found = 1'b1;
            coin  = DOLLAR;
        end else if (inv_nz[QUARTER] && remain_cents >= QUARTER_CENTS) begin
            found = 1'b1;
            coin  = QUARTER;
        end else if (inv_nz[DIME] && remain_cents >= DIME_CENTS) begin
            found = 1'b1;
            coin  = DIME;
        end else if (inv_nz[NICKEL] && remain_cents >= NICKEL_CENTS) begin
            found = 1'b1;
            coin  = NICKEL;
        end
    end

endmodule

// File: rtl/coin_change_sequencer.sv
// Change payout sequencer: accepts an amount in cents, then ejects coins one at a
// time, largest affordable in-stock coin first, until nothing more can be paid.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   bus (slave)       : request and ejection handshakes
//   refill/refill_coin: add one coin of the given denomination to inventory
//   done, short       : end-of-transaction pulse; short flags an unpaid residue
//   remain_cents      : unpaid residue of the current / last transaction
//   change_*          : coins ejected per denomination in the current / last transaction
module coin_change_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned INV_W    = 4,
    parameter int unsigned INIT_INV = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    coin_change_sequencer_if.slave bus,
    input  logic                   refill,
    input  coin_t                  refill_coin,
    output logic                   done,
    output logic                   short,
    output logic [7:0]             remain_cents,
    output logic [5:0]             change_nickels,
    output logic [5:0]             change_dimes,
    output logic [5:0]             change_quarters,
    output logic [5:0]             change_dollar
);

    localparam logic [INV_W-1:0] INV_INIT = INV_W'(INIT_INV);
    localparam logic [INV_W-1:0] INV_MAX  = '1;

    state_t                  state_q, state_d;
    coin_t                   coin_q, coin_d;
    logic [7:0]              remain_q, remain_d;
    logic [3:0][5:0]         cnt_q, cnt_d;
    logic [3:0][INV_W-1:0]   inv_q, inv_d;
    logic [3:0]              inv_nz;
    logic                    sel_found;
    coin_t                   sel_coin;
    logic                    accept;
    logic                    ack_fire;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inv_nz[i] = |inv_q[i];
        end
    end

    coin_select u_coin_select (
        .remain_cents (remain_q),
        .inv_nz       (inv_nz),
        .found        (sel_found),
        .coin         (sel_coin)
    );

    assign accept   = (state_q == IDLE) && bus.req_valid;
    // Acks outside EJECT are not a handshake and must not touch any state.
    assign ack_fire = (state_q == EJECT) && bus.eject_ack;

    always_comb begin
        state_d  = state_q;
        coin_d   = coin_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    remain_d = bus.req_cents;
                    cnt_d    = '0;
                    state_d  = SELECT;
                end
            end
            SELECT: begin
                if (sel_found) begin
                    coin_d  = sel_coin;
                    state_d = EJECT;
                end else begin
                    state_d = DONE;
                end
            end
            EJECT: begin
                if (ack_fire) begin
                    remain_d        = remain_q - coin_value(coin_q);
                    cnt_d[coin_q]   = cnt_q[coin_q] + 6'd1;
                    state_d         = SELECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A refill and an ejection of the same coin on one edge cancel out; a refill
    // into a full counter is dropped.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inv_d[i] = inv_q[i];
            if (ack_fire && coin_q == coin_t'(i)) begin
                if (!(refill && refill_coin == coin_t'(i))) begin
                    inv_d[i] = inv_q[i] - 1'b1;
                end
            end else if (refill && refill_coin == coin_t'(i) && inv_q[i] != INV_MAX) begin
                inv_d[i] = inv_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            coin_q   <= NICKEL;
            remain_q <= '0;
            cnt_q    <= '0;
            inv_q    <= {4{INV_INIT}};
        end else begin
            state_q  <= state_d;
            coin_q   <= coin_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            inv_q    <= inv_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.eject_valid = (state_q == EJECT);
    assign bus.eject_coin  = coin_q;

    assign done            = (state_q == DONE);
    assign short           = (state_q == DONE) && (remain_q != 8'd0);
    assign remain_cents    = remain_q;
    assign change_nickels  = cnt_q[NICKEL];
    assign change_dimes    = cnt_q[DIME];
    assign change_quarters = cnt_q[QUARTER];
    assign change_dollar   = cnt_q[DOLLAR];

    // The hoppers rely on the coin code holding steady until they ack it.
    a_coin_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.eject_valid && !bus.eject_ack) |=> (bus.eject_valid && $stable(bus.eject_coin))
    );

endmodule

// File: tb/tb_coin_change_sequencer.sv
module tb_coin_change_sequencer;
    import vend_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       refill;
    coin_t      refill_coin;
    logic       done;
    logic       short;
    logic [7:0] remain_cents;
    logic [5:0] change_nickels, change_dimes, change_quarters, change_dollar;

    coin_change_sequencer_if bus ();

    coin_change_sequencer #(
        .INV_W    (4),
        .INIT_INV (15)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus.slave),
        .refill          (refill),
        .refill_coin     (refill_coin),
        .done            (done),
        .short           (short),
        .remain_cents    (remain_cents),
        .change_nickels  (change_nickels),
        .change_dimes    (change_dimes),
        .change_quarters (change_quarters),
        .change_dollar   (change_dollar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Results of the last do_txn call.
    coin_t ejected [$];
    bit    got_done;
    logic  got_short;
    int    done_lat;
    bit    coin_unstable;
    logic  done_after;

    function automatic string seq_str();
        string s = "";
        foreach (ejected[i]) begin
            case (ejected[i])
                NICKEL:  s = {s, "N"};
                DIME:    s = {s, "D"};
                QUARTER: s = {s, "Q"};
                default: s = {s, "$"};
            endcase
        end
        return s;
    endfunction

    function automatic logic [23:0] counts();
        return {change_dollar, change_quarters, change_dimes, change_nickels};
    endfunction

    function automatic logic [15:0] inv_all();
        return {dut.inv_q[DOLLAR], dut.inv_q[QUARTER], dut.inv_q[DIME], dut.inv_q[NICKEL]};
    endfunction

    // Hopper model: runs one transaction from a negedge in IDLE and returns at the
    // negedge after done. refill_on_ack >= 0 pulses refill of that coin with each ack.
    task automatic do_txn(input logic [7:0] cents, input int ack_delay, input int refill_on_ack);
        int    cyc;
        coin_t coin;
        ejected.delete();
        got_done = 0; got_short = 1'b0; done_lat = 0; coin_unstable = 0; done_after = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_cents = cents;
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 400) begin
            if (bus.eject_valid) begin
                coin = bus.eject_coin;
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge clk);
                    cyc++;
                    if (!bus.eject_valid || bus.eject_coin !== coin) coin_unstable = 1;
                end
                bus.eject_ack = 1'b1;
                if (refill_on_ack >= 0) begin
                    refill      = 1'b1;
                    refill_coin = coin_t'(refill_on_ack);
                end
                ejected.push_back(coin);
                @(negedge clk);
                cyc++;
                bus.eject_ack = 1'b0;
                refill        = 1'b0;
            end else if (done) begin
                got_done  = 1;
                got_short = short;
                done_lat  = cyc;
                @(negedge clk);
                done_after = done;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_done) begin
            vectors++;
            miscompares++;
            $display("FAIL txn_timeout: no done within %0d cycles for %0d cents", cyc, cents);
        end
    endtask

    task automatic do_refill(input coin_t coin);
        refill      = 1'b1;
        refill_coin = coin;
        @(negedge clk);
        refill      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; refill = 1'b0; refill_coin = NICKEL;
        bus.req_valid = 1'b0; bus.req_cents = '0; bus.eject_ack = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.eject_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_eject_valid: got %b expected 0", bus.eject_valid);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({bus.req_ready, bus.eject_valid, done, short} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rst_flags: got rdy/ev/done/short=%b expected 1000",
                     {bus.req_ready, bus.eject_valid, done, short});
        end
        vectors++;
        if (remain_cents !== 8'd0 || counts() !== 24'd0) begin
            miscompares++;
            $display("FAIL rst_remain_counts: got %0d/%h expected 0/0", remain_cents, counts());
        end
        vectors++;
        if (inv_all() !== 16'hFFFF) begin
            miscompares++; $display("FAIL rst_inventory: got %h expected ffff", inv_all());
        end
        @(negedge clk);
    endtask

    task automatic test_greedy();
        do_txn(8'd85, 0, -1);
        vectors++;
        if (seq_str() != "QQQD") begin
            miscompares++; $display("FAIL seq_85: got '%s' expected 'QQQD'", seq_str());
        end
        vectors++;
        if ({got_short, remain_cents, done_after} !== {1'b0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL end_85: got short=%b remain=%0d done_after=%b expected 0/0/0",
                     got_short, remain_cents, done_after);
        end
        vectors++;
        if (counts() !== {6'd0, 6'd3, 6'd1, 6'd0}) begin
            miscompares++; $display("FAIL counts_85: got %h expected %h", counts(),
                                    {6'd0, 6'd3, 6'd1, 6'd0});
        end
        vectors++;
        if (inv_all() !== 16'hFCEF) begin
            miscompares++; $display("FAIL inv_85: got %h expected fcef", inv_all());
        end

        do_txn(8'd255, 0, -1);
        vectors++;
        if (seq_str() != "$$QQN") begin
            miscompares++; $display("FAIL seq_255: got '%s' expected '$$QQN'", seq_str());
        end
        vectors++;
        if (counts() !== {6'd2, 6'd2, 6'd0, 6'd1} || remain_cents !== 8'd0) begin
            miscompares++;
            $display("FAIL counts_255: got %h remain=%0d expected %h remain=0", counts(),
                     remain_cents, {6'd2, 6'd2, 6'd0, 6'd1});
        end
        vectors++;
        if (inv_all() !== 16'hDAEE) begin
            miscompares++; $display("FAIL inv_255: got %h expected daee", inv_all());
        end
    endtask

    task automatic test_fallback();
        // Drain the ten remaining quarters.
        for (int i = 0; i < 10; i++) begin
            do_txn(8'd25, 0, -1);
            vectors++;
            if (seq_str() != "Q") begin
                miscompares++; $display("FAIL drain_q%0d: got '%s' expected 'Q'", i, seq_str());
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_txn(8'd30, 0, -1);
            vectors++;
            if (seq_str() != "DDD") begin
                miscompares++; $display("FAIL seq_30_%0d: got '%s' expected 'DDD'", i, seq_str());
            end
        end
        do_txn(8'd30, 0, -1);
        vectors++;
        if (seq_str() != "DDNN" || counts() !== {6'd0, 6'd0, 6'd2, 6'd2}) begin
            miscompares++;
            $display("FAIL seq_30_mix: got '%s' counts %h expected 'DDNN' counts %h", seq_str(),
                     counts(), {6'd0, 6'd0, 6'd2, 6'd2});
        end
        do_txn(8'd30, 0, -1);
        vectors++;
        if (seq_str() != "NNNNNN" || got_short !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_30_nickels: got '%s' short=%b expected 'NNNNNN' short=0",
                     seq_str(), got_short);
        end
        vectors++;
        if (inv_all() !== 16'hD006) begin
            miscompares++; $display("FAIL inv_fallback: got %h expected d006", inv_all());
        end
    endtask

    task automatic test_short_and_zero();
        do_txn(8'd7, 0, -1);
        vectors++;
        if (seq_str() != "N" || got_short !== 1'b1 || remain_cents !== 8'd2) begin
            miscompares++;
            $display("FAIL short_7: got '%s' short=%b remain=%0d expected 'N' short=1 remain=2",
                     seq_str(), got_short, remain_cents);
        end
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_ready: got %b expected 1", bus.req_ready);
        end
        do_txn(8'd0, 0, -1);
        vectors++;
        if (seq_str() != "" || done_lat != 2 || got_short !== 1'b0 || done_after !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_amt: got '%s' lat=%0d short=%b done_after=%b expected '' 2 0 0",
                     seq_str(), done_lat, got_short, done_after);
        end
        vectors++;
        if (remain_cents !== 8'd0 || counts() !== 24'd0) begin
            miscompares++;
            $display("FAIL zero_clear: got remain=%0d counts=%h expected 0/0", remain_cents,
                     counts());
        end
    endtask

    task automatic test_ack_and_refill();
        // Stray ack in IDLE must be ignored.
        bus.eject_ack = 1'b1;
        @(negedge clk);
        bus.eject_ack = 1'b0;
        vectors++;
        if (inv_all() !== 16'hD005 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_ack: got inv=%h rdy=%b expected d005 1", inv_all(),
                     bus.req_ready);
        end
        for (int i = 0; i < 16; i++) do_refill(DIME);
        vectors++;
        if (dut.inv_q[DIME] !== 4'd15) begin
            miscompares++; $display("FAIL refill_sat: got %0d expected 15", dut.inv_q[DIME]);
        end
        do_refill(QUARTER);
        do_txn(8'd25, 3, -1);
        vectors++;
        if (seq_str() != "Q" || coin_unstable || dut.inv_q[QUARTER] !== 4'd0) begin
            miscompares++;
            $display("FAIL slow_ack: got '%s' unstable=%0d invq=%0d expected 'Q' 0 0",
                     seq_str(), coin_unstable, dut.inv_q[QUARTER]);
        end
        do_refill(QUARTER);
        do_txn(8'd25, 0, QUARTER);
        vectors++;
        if (seq_str() != "Q" || dut.inv_q[QUARTER] !== 4'd1) begin
            miscompares++;
            $display("FAIL refill_same: got '%s' invq=%0d expected 'Q' 1", seq_str(),
                     dut.inv_q[QUARTER]);
        end
        do_txn(8'd25, 0, NICKEL);
        vectors++;
        if (inv_all() !== 16'hD0F6) begin
            miscompares++; $display("FAIL refill_other: got %h expected d0f6", inv_all());
        end
    endtask

    task automatic test_reset_mid_eject();
        bit done_seen = 0;
        bus.req_valid = 1'b1;
        bus.req_cents = 8'd100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.eject_valid !== 1'b1 || bus.eject_coin !== DOLLAR) begin
            miscompares++;
            $display("FAIL pre_rst_eject: got ev=%b coin=%0d expected 1 3", bus.eject_valid,
                     bus.eject_coin);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.eject_valid !== 1'b0) begin
            miscompares++; $display("FAIL async_drop: got %b expected 0", bus.eject_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 if (done) done_seen = 1;
            @(negedge clk);
        end
        vectors++;
        if (done_seen || bus.req_ready !== 1'b1 || inv_all() !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL post_rst: got done_seen=%0d rdy=%b inv=%h expected 0 1 ffff",
                     done_seen, bus.req_ready, inv_all());
        end
        do_txn(8'd85, 0, -1);
        vectors++;
        if (seq_str() != "QQQD" || counts() !== {6'd0, 6'd3, 6'd1, 6'd0}) begin
            miscompares++;
            $display("FAIL after_rst_85: got '%s' counts %h expected 'QQQD' %h", seq_str(),
                     counts(), {6'd0, 6'd3, 6'd1, 6'd0});
        end
    endtask

    initial begin
        test_reset();
        test_greedy();
        test_fallback();
        test_short_and_zero();
        test_ack_and_refill();
        test_reset_mid_eject();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
